// File: rtl/wrapper_output_capture_buffer.sv
// Capture buffer behind a compute engine. Only engine strobes that answer an
// accepted last-beat are kept; they are queued in a small FIFO for the DMA side.
module wrapper_output_capture_buffer #(
   parameter int DATAWIDTH = 256,
   parameter int DEPTH     = 4,
   parameter int PENDWIDTH = 4,
   parameter int CNTWIDTH  = 16
) (
   input  logic                       HCLK,
   input  logic                       HRESETn,
   input  logic                       sync_rst,
   input  logic                       in_valid,
   input  logic                       in_ready,
   input  logic                       in_last,
   input  logic [DATAWIDTH-1:0]       eng_data,
   input  logic                       eng_valid,
   output logic [DATAWIDTH-1:0]       out_data,
   output logic                       out_valid,
   output logic                       out_last,
   input  logic                       out_ready,
   input  logic [$clog2(DEPTH):0]     req_thresh,
   output logic                       out_data_req,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic                       pend_err,
   output logic [CNTWIDTH-1:0]        drop_count,
   input  logic                       clear_status
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DATAWIDTH-1:0] mem_q [DEPTH];
   logic [DATAWIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic [PENDWIDTH-1:0] pending_q, pending_d;
   logic                 overflow_q, overflow_d;
   logic                 pend_err_q, pend_err_d;
   logic [CNTWIDTH-1:0]  drop_count_q, drop_count_d;

   logic last_acc, final_res, pop, push, full, drop_ev, pend_ev;

   always_comb begin
      last_acc  = in_valid & in_ready & in_last;
      final_res = eng_valid & (pending_q != '0);
      full      = (level_q == LW'(DEPTH));
      pop       = (level_q != '0) & out_ready;
      // a full FIFO still accepts when the head leaves in the same cycle
      push      = final_res & (~full | pop);
      drop_ev   = final_res & full & ~pop;
      pend_ev   = last_acc & ~final_res & (pending_q == '1);

      pending_d = pending_q;
      if (last_acc && !final_res) begin
         if (pending_q != '1) pending_d = pending_q + PENDWIDTH'(1);
      end else if (final_res && !last_acc) begin
         pending_d = pending_q - PENDWIDTH'(1);
      end

      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = eng_data;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      overflow_d   = clear_status ? 1'b0 : overflow_q;
      pend_err_d   = clear_status ? 1'b0 : pend_err_q;
      drop_count_d = clear_status ? '0 : drop_count_q;
      if (drop_ev) begin
         overflow_d = 1'b1;
         if (drop_count_d != '1) drop_count_d = drop_count_d + CNTWIDTH'(1);
      end
      if (pend_ev) pend_err_d = 1'b1;

      if (sync_rst) begin
         for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         level_d      = '0;
         pending_d    = '0;
         overflow_d   = 1'b0;
         pend_err_d   = 1'b0;
         drop_count_d = '0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         pending_q    <= '0;
         overflow_q   <= 1'b0;
         pend_err_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         pending_q    <= pending_d;
         overflow_q   <= overflow_d;
         pend_err_q   <= pend_err_d;
         drop_count_q <= drop_count_d;
      end
   end

   always_comb begin
      out_valid    = (level_q != '0);
      out_last     = out_valid;
      out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
      out_data_req = (req_thresh != '0) && (level_q >= req_thresh);
      level        = level_q;
      overflow     = overflow_q;
      pend_err     = pend_err_q;
      drop_count   = drop_count_q;
   end

endmodule

// File: tb/tb_wrapper_output_capture_buffer.sv
// Scoreboard bench for the output capture buffer; a second instance with a
// 2-bit pending counter exercises pending saturation.
module tb_wrapper_output_capture_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int PMAX  = 15;

   logic          HCLK = 1'b0;
   logic          HRESETn, sync_rst;
   logic          in_valid, in_ready, in_last;
   logic [DW-1:0] eng_data;
   logic          eng_valid, out_ready, clear_status;
   logic [2:0]    req_thresh;

   logic [DW-1:0] out_data, out_data_p2;
   logic          out_valid, out_last, out_data_req, overflow, pend_err;
   logic          out_valid_p2, out_last_p2, out_data_req_p2, overflow_p2, pend_err_p2;
   logic [2:0]    level, level_p2;
   logic [15:0]   drop_count, drop_count_p2;

   always #5 HCLK = ~HCLK;

   wrapper_output_capture_buffer #(.DATAWIDTH(DW), .DEPTH(DEPTH), .PENDWIDTH(4), .CNTWIDTH(16)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .sync_rst(sync_rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .eng_data(eng_data), .eng_valid(eng_valid),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .req_thresh(req_thresh), .out_data_req(out_data_req), .level(level),
      .overflow(overflow), .pend_err(pend_err), .drop_count(drop_count),
      .clear_status(clear_status));

   wrapper_output_capture_buffer #(.DATAWIDTH(DW), .DEPTH(DEPTH), .PENDWIDTH(2), .CNTWIDTH(16)) dut_p2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .sync_rst(sync_rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .eng_data(eng_data), .eng_valid(eng_valid),
      .out_data(out_data_p2), .out_valid(out_valid_p2), .out_last(out_last_p2), .out_ready(out_ready),
      .req_thresh(req_thresh), .out_data_req(out_data_req_p2), .level(level_p2),
      .overflow(overflow_p2), .pend_err(pend_err_p2), .drop_count(drop_count_p2),
      .clear_status(clear_status));

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] sb[$];
   int pend    = 0;
   bit m_ovf   = 0;
   bit m_perr  = 0;
   int m_drops = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      sb.delete();
      pend    = 0;
      m_ovf   = 0;
      m_perr  = 0;
      m_drops = 0;
   endtask

   // Called at a falling edge with inputs already driven: checks, models, advances one cycle.
   task automatic tick();
      bit lst, fin, full, pop, evt_drop, evt_perr;
      logic [DW-1:0] exp_word;
      full = (sb.size() == DEPTH);
      pop  = (sb.size() > 0) && out_ready;
      chk("level", 64'(level), 64'(sb.size()));
      chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
      chk("out_last", 64'(out_last), 64'(sb.size() > 0));
      chk("out_data_req", 64'(out_data_req), 64'((req_thresh != 0) && (sb.size() >= int'(req_thresh))));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("pend_err", 64'(pend_err), 64'(m_perr));
      chk("drop_count", 64'(drop_count), 64'(m_drops));
      if (sb.size() == 0) chk("idle_data", 64'(out_data), 64'd0);
      if (pop) begin
         exp_word = sb.pop_front();
         chk("pop_data", 64'(out_data), 64'(exp_word));
      end
      if (sync_rst) begin
         model_clear();
      end else begin
         lst      = in_valid && in_ready && in_last;
         fin      = eng_valid && (pend > 0);
         evt_drop = fin && full && !pop;
         evt_perr = lst && !fin && (pend == PMAX);
         if (clear_status) begin
            m_ovf = 0; m_perr = 0; m_drops = 0;
         end
         if (evt_drop) begin
            m_ovf = 1;
            if (m_drops != 65535) m_drops++;
         end
         if (evt_perr) m_perr = 1;
         if (lst && !fin) begin
            if (pend < PMAX) pend++;
         end else if (fin && !lst) begin
            pend--;
         end
         if (fin && !evt_drop) sb.push_back(eng_data);
      end
      @(posedge HCLK);
      @(negedge HCLK);
   endtask

   task automatic idle();
      in_valid = 0; in_ready = 0; in_last = 0; eng_valid = 0;
      sync_rst = 0; clear_status = 0;
   endtask

   task automatic last_accepts(input int n);
      for (int i = 0; i < n; i++) begin
         idle(); in_valid = 1; in_ready = 1; in_last = 1;
         tick();
      end
      idle();
   endtask

   task automatic strobes(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         idle(); eng_valid = 1; eng_data = base + DW'(i);
         tick();
      end
      idle();
   endtask

   task automatic drain();
      out_ready = 1;
      for (int i = 0; i < DEPTH + 1; i++) tick();
      out_ready = 0;
   endtask

   initial begin
      HRESETn = 0; idle(); eng_data = '0; out_ready = 0; req_thresh = 0;
      @(negedge HCLK);
      @(negedge HCLK);
      chk("rst_level", 64'(level), 0);
      chk("rst_valid", 64'(out_valid), 0);
      chk("rst_data", 64'(out_data), 0);
      HRESETn = 1;
      @(negedge HCLK);

      // intermediate strobes discarded, only the answer to a last-accept is kept
      strobes(3, 32'hDEAD_0000);
      last_accepts(1);
      strobes(1, 32'hAAAA_0001);
      tick();
      drain();

      // overflow: six results into a four-entry buffer
      last_accepts(6);
      strobes(6, 32'h0000_0100);
      tick();
      drain();
      idle(); clear_status = 1; tick(); idle();

      // full buffer with a same-cycle pop accepts the new word
      last_accepts(5);
      strobes(4, 32'h0000_0200);
      idle(); eng_valid = 1; eng_data = 32'h0000_02FF; out_ready = 1;
      tick();
      idle();
      drain();

      // request threshold
      req_thresh = 2;
      last_accepts(2);
      strobes(1, 32'h0000_0300);
      tick();
      strobes(1, 32'h0000_0301);
      tick();
      drain();

      // drop and clear_status in the same cycle: the event wins
      last_accepts(5);
      strobes(4, 32'h0000_0400);
      idle(); eng_valid = 1; eng_data = 32'h0000_04FF; clear_status = 1;
      tick();
      idle();
      tick();
      drain();

      // pending saturation on the 2-bit instance
      idle(); sync_rst = 1; tick(); idle();
      last_accepts(4);
      chk("p2_pend_err_set", 64'(pend_err_p2), 1);
      idle(); clear_status = 1; tick(); idle();
      chk("p2_pend_err_clr", 64'(pend_err_p2), 0);
      strobes(4, 32'h0000_0500);
      chk("p2_level_pend3", 64'(level_p2), 3);
      chk("p2_overflow", 64'(overflow_p2), 0);
      idle(); sync_rst = 1; tick(); idle();

      // async reset mid-operation
      last_accepts(5);
      strobes(3, 32'h0000_0600);
      tick();
      #2 HRESETn = 0;
      #1;
      chk("ar_valid", 64'(out_valid), 0);
      chk("ar_last", 64'(out_last), 0);
      chk("ar_data", 64'(out_data), 0);
      chk("ar_req", 64'(out_data_req), 0);
      chk("ar_level", 64'(level), 0);
      chk("ar_overflow", 64'(overflow), 0);
      chk("ar_pend_err", 64'(pend_err), 0);
      chk("ar_drops", 64'(drop_count), 0);
      model_clear();
      @(posedge HCLK);
      @(negedge HCLK);
      HRESETn = 1;
      strobes(2, 32'h0000_0700);
      tick();
      last_accepts(1);
      strobes(1, 32'h0000_07AA);
      tick();
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
